// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read stage: turns a FIFO empty/rd_en port into a valid/ready stream
// with a two-entry skid buffer and a saturating delivered-word counter.
module fifo_rd_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            buf_count,
    output logic [CNT_WIDTH-1:0]  word_count
);

    logic [DATA_WIDTH-1:0] entry0_r;
    logic [DATA_WIDTH-1:0] entry1_r;
    logic [1:0]            count_r;
    logic                  valid_r;
    logic                  inflight_r;
    logic [CNT_WIDTH-1:0]  word_cnt_r;

    logic                  pop_s;
    logic                  push_s;
    logic [2:0]            credit_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] entry0_nxt_s;
    logic [DATA_WIDTH-1:0] entry1_nxt_s;
    logic [1:0]            count_nxt_s;
    logic [CNT_WIDTH-1:0]  word_cnt_nxt_s;

    // Handshake decode and read issue; credits count buffered plus inflight words
    always_comb begin
        pop_s    = valid_r & m_ready;
        push_s   = inflight_r;
        credit_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_en_s  = ~rd_rst & ~fifo_empty & (credit_s < 3'd2);
    end

    // Next buffer state from current occupancy and push/pop
    always_comb begin
        entry0_nxt_s = entry0_r;
        entry1_nxt_s = entry1_r;
        count_nxt_s  = count_r;
        case ({count_r, push_s, pop_s})
            4'b00_10: begin
                entry0_nxt_s = fifo_rd_data;
                count_nxt_s  = 2'd1;
            end
            4'b01_10: begin
                entry1_nxt_s = fifo_rd_data;
                count_nxt_s  = 2'd2;
            end
            4'b01_01: begin
                count_nxt_s  = 2'd0;
            end
            4'b01_11: begin
                entry0_nxt_s = fifo_rd_data;
                count_nxt_s  = 2'd1;
            end
            4'b10_01: begin
                entry0_nxt_s = entry1_r;
                count_nxt_s  = 2'd1;
            end
            4'b10_11: begin
                entry0_nxt_s = entry1_r;
                entry1_nxt_s = fifo_rd_data;
                count_nxt_s  = 2'd2;
            end
            default: begin
                entry0_nxt_s = entry0_r;
                entry1_nxt_s = entry1_r;
                count_nxt_s  = count_r;
            end
        endcase
    end

    // Saturating delivered-word counter
    always_comb begin
        if (pop_s && (word_cnt_r != {CNT_WIDTH{1'b1}})) begin
            word_cnt_nxt_s = word_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_nxt_s = word_cnt_r;
        end
    end

    // State and output registers
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            entry0_r   <= {DATA_WIDTH{1'b0}};
            entry1_r   <= {DATA_WIDTH{1'b0}};
            count_r    <= 2'd0;
            valid_r    <= 1'b0;
            inflight_r <= 1'b0;
            word_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            entry0_r   <= entry0_nxt_s;
            entry1_r   <= entry1_nxt_s;
            count_r    <= count_nxt_s;
            valid_r    <= (count_nxt_s != 2'd0);
            inflight_r <= rd_en_s;
            word_cnt_r <= word_cnt_nxt_s;
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_data     = entry0_r;
    assign m_valid    = valid_r;
    assign buf_count  = count_r;
    assign word_count = word_cnt_r;

endmodule

// Credit checker: buffered words plus the outstanding read never exceed the two entries.
module fifo_rd_fwft_chk (
    input logic       rd_clk,
    input logic       rd_rst,
    input logic       fifo_rd_en,
    input logic [1:0] buf_count
);

    logic inflight_r;

    // Mirror of the outstanding-read flag
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fifo_rd_en;
        end
    end

    credit_limit: assert property (@(posedge rd_clk) disable iff (rd_rst)
        ({1'b0, buf_count} + {2'b00, inflight_r}) <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: table-driven latency vectors, then an emulated FIFO with a scoreboard.
module tb_fifo_rd_fwft;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        fifo_empty;
    logic        m_ready;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en,  fifo_rd_en4;
    logic [7:0]  m_data,      m_data4;
    logic        m_valid,     m_valid4;
    logic [1:0]  buf_count,   buf_count4;
    logic [15:0] word_count16;
    logic [3:0]  word_count4;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_pops = 0;
    int          n_reads = 0;
    logic        inflight_m = 1'b0;
    logic [7:0]  mem_q[$];
    logic [7:0]  exp_q[$];

    typedef struct {
        logic       empty;
        logic       ready;
        logic [7:0] data;
        logic       exp_rd;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_cnt;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t tbl[6];

    fifo_rd_fwft #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .buf_count(buf_count), .word_count(word_count16));

    fifo_rd_fwft #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en4),
        .fifo_rd_data(fifo_rd_data), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .buf_count(buf_count4), .word_count(word_count4));

    fifo_rd_fwft_chk chk_u (.rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(fifo_rd_en), .buf_count(buf_count));

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic load(input logic [7:0] w);
        mem_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock of the emulated FIFO plus scoreboard checks
    task automatic cyc();
        logic       rd_s;
        logic [7:0] e;
        #1;
        rd_s = fifo_rd_en;
        chk("credit", 32'(({1'b0, buf_count} + {2'b00, inflight_m}) <= 3'd2), 32'd1);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                fail("spurious_word");
            end else begin
                e = exp_q.pop_front();
                chk("data_order", 32'(m_data), 32'(e));
            end
            n_pops++;
        end
        if (rd_s) n_reads++;
        @(posedge rd_clk);
        #1;
        inflight_m = rd_s;
        if (rd_s) begin
            if (mem_q.size() == 0) begin
                fail("read_when_empty");
                fifo_rd_data = 8'($urandom);
            end else begin
                fifo_rd_data = mem_q.pop_front();
            end
        end else begin
            fifo_rd_data = 8'($urandom);
        end
        fifo_empty = (mem_q.size() == 0);
        chk("word_count16", 32'(word_count16), 32'(n_pops));
        chk("word_count4", 32'(word_count4), 32'((n_pops > 15) ? 15 : n_pops));
    endtask

    // One-cycle reset; the FIFO behind the stage resets along with it
    task automatic do_reset();
        rd_rst = 1'b1;
        #1;
        chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
        @(posedge rd_clk);
        #1;
        rd_rst       = 1'b0;
        mem_q.delete();
        exp_q.delete();
        fifo_empty   = 1'b1;
        fifo_rd_data = 8'($urandom);
        inflight_m   = 1'b0;
        n_pops       = 0;
        n_reads      = 0;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_count", 32'(buf_count), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_wc16", 32'(word_count16), 32'd0);
        chk("rst_wc4", 32'(word_count4), 32'd0);
    endtask

    initial begin
        logic [7:0] first;
        logic       found;

        tbl[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 2'd0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 8'hA1, 2'd1, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA2, 2'd1, 16'd1};
        tbl[4] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 8'hA3, 2'd1, 16'd2};
        tbl[5] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'hA3, 2'd0, 16'd3};

        rd_rst = 1'b1;
        fifo_empty = 1'b1;
        m_ready = 1'b0;
        fifo_rd_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rd_en_hold_reset", 32'(fifo_rd_en), 32'd0);
            @(posedge rd_clk);
            #1;
        end
        do_reset();

        // Latency and back-to-back delivery of A1, A2, A3
        for (int i = 0; i < 6; i++) begin
            fifo_empty   = tbl[i].empty;
            m_ready      = tbl[i].ready;
            fifo_rd_data = tbl[i].data;
            #1;
            chk($sformatf("v%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].exp_rd));
            chk($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk($sformatf("v%0d_data", i), 32'(m_data), 32'(tbl[i].exp_data));
            chk($sformatf("v%0d_count", i), 32'(buf_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("v%0d_wc", i), 32'(word_count16), 32'(tbl[i].exp_wc));
            @(posedge rd_clk);
            #1;
        end

        // Stalled consumer: only two reads issue, head stays stable, then drains without gaps
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(8'h30 + i));
        first = exp_q[0];
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i >= 3) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(first));
            end
        end
        chk("stall_reads", 32'(n_reads), 32'd2);
        chk("stall_count", 32'(buf_count), 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            chk("no_gap", 32'(m_valid), 32'd1);
            cyc();
        end
        chk("stall_drained", 32'(exp_q.size()), 32'd0);
        chk("stall_wc", 32'(word_count16), 32'd5);

        // Toggling ready over 20 random words; the 4-bit counter saturates
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) load(8'($urandom_range(255)));
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            m_ready = ~m_ready;
            cyc();
        end
        m_ready = 1'b0;
        chk("toggle_drained", 32'(exp_q.size()), 32'd0);
        chk("toggle_pops", 32'(n_pops), 32'd20);
        chk("toggle_wc16", 32'(word_count16), 32'd20);
        chk("toggle_wc4_sat", 32'(word_count4), 32'd15);
        cyc();
        chk("toggle_wc4_hold", 32'(word_count4), 32'd15);

        // Reset with a buffered word and a read outstanding
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(8'hC0 + i));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            #1;
            found = (buf_count == 2'd1) && inflight_m;
        end
        if (!found) fail("mid_reset_setup_timeout");
        do_reset();
        m_ready = 1'b1;
        cyc();
        chk("post_rst_valid", 32'(m_valid), 32'd0);
        chk("post_rst_count", 32'(buf_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
